// File: rtl/gf26_forney.sv
// Forney error-magnitude stage for the GF(2^6) Reed-Solomon decoder: e = Omega(X^-1) / Lambda'(X^-1).
// Optional macro GF26_FORNEY_FCR0_EN selects first consecutive root alpha^0 (extra loc multiply).
package gf26_pkg;
    // Shift-and-add multiply modulo x^6+x+1.
    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] acc;
        logic [5:0] sh;
        // NOTE: blocking assignments are correct here; this is combinational function scope, not state.
        acc = '0;
        sh  = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[4:0], 1'b0} ^ (sh[5] ? 6'h03 : 6'h00);
        end
        return acc;
    endfunction
endpackage

// Multiplicative inverse by stepping a candidate through powers of alpha until cand*base == 1.
module gf26_inverse (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic [5:0] base,
    output logic       finish_flag,
    output logic [5:0] z
);
    import gf26_pkg::*;

    logic       running;
    logic [5:0] base_q;
    logic [5:0] cand;
    logic [5:0] tries;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            running     <= 1'b0;
            base_q      <= '0;
            cand        <= '0;
            tries       <= '0;
            finish_flag <= 1'b0;
            z           <= '0;
        end else if (start) begin
            running     <= 1'b1;
            base_q      <= base;
            cand        <= 6'h01;
            tries       <= '0;
            finish_flag <= 1'b0;
        end else if (running) begin
            if (gf_mul(cand, base_q) == 6'h01) begin
                z           <= cand;
                finish_flag <= 1'b1;
                running     <= 1'b0;
            end else if (tries == 6'd62) begin
                // Base was zero: no inverse exists, report 0.
                z           <= '0;
                finish_flag <= 1'b1;
                running     <= 1'b0;
            end else begin
                cand  <= gf_mul(cand, 6'h02);
                tries <= tries + 6'd1;
            end
        end
    end
endmodule

module gf26_forney #(
    parameter int T = 3,
    parameter int M = 6
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic [M-1:0]     loc,
    input  logic [M*T-1:0]   omega,
    input  logic [M*(T+1)-1:0] lambda,
    output logic             busy,
    output logic             finish_flag,
    output logic             fail_flag,
    output logic [M-1:0]     err_val
);
    import gf26_pkg::*;

    localparam int IW = (T > 1) ? $clog2(T) : 1;

    typedef enum logic [3:0] {
        IDLE, INV_LOC, WAIT_LOC, EVAL, CHECK, INV_DEN, WAIT_DEN, MUL, DONE
    } state_t;

    state_t state, next_state;

    logic                  start_q;
    logic [M-1:0]          loc_q;
    logic [M*T-1:0]        omega_q;
    logic [M*(T+1)-1:0]    lambda_q;
    logic [M-1:0]          xinv, deninv, num, den;
    logic [IW-1:0]         idx;
    logic [1:0]            wcnt;
`ifdef GF26_FORNEY_FCR0_EN
    logic                  mul_phase;
`endif

    logic                  accept;
    logic                  inv_start;
    logic [M-1:0]          inv_base;
    logic                  inv_done;
    logic [M-1:0]          inv_z;
    logic [M-1:0]          om_coef;
    logic [M-1:0]          dl_coef;

    assign accept = (state == IDLE) && start && !start_q;
    assign busy   = (state != IDLE) && (state != DONE);

    gf26_inverse u_inv (
        .clk         (clk),
        .resetN      (resetN),
        .start       (inv_start),
        .base        (inv_base),
        .finish_flag (inv_done),
        .z           (inv_z)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        next_state = state;
        inv_start  = 1'b0;
        inv_base   = loc_q;
        // Lambda' keeps only odd-index terms: coefficient of x^j is lambda_(j+1) for even j.
        om_coef    = omega_q[M*int'(idx) +: M];
        dl_coef    = idx[0] ? '0 : lambda_q[M*(int'(idx)+1) +: M];
        unique case (state)
            IDLE:     if (accept) next_state = (loc == '0) ? DONE : INV_LOC;
            INV_LOC:  begin inv_start = 1'b1; next_state = WAIT_LOC; end
            WAIT_LOC: if (wcnt == 2'd2 && inv_done) next_state = EVAL;
            EVAL:     if (idx == '0) next_state = CHECK;
            CHECK:    next_state = (den == '0) ? DONE : INV_DEN;
            INV_DEN:  begin inv_start = 1'b1; inv_base = den; next_state = WAIT_DEN; end
            WAIT_DEN: if (wcnt == 2'd2 && inv_done) next_state = MUL;
`ifdef GF26_FORNEY_FCR0_EN
            MUL:      if (mul_phase) next_state = DONE;
`else
            MUL:      next_state = DONE;
`endif
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            start_q     <= 1'b0;
            loc_q       <= '0;
            omega_q     <= '0;
            lambda_q    <= '0;
            xinv        <= '0;
            deninv      <= '0;
            num         <= '0;
            den         <= '0;
            idx         <= '0;
            wcnt        <= '0;
`ifdef GF26_FORNEY_FCR0_EN
            mul_phase   <= 1'b0;
`endif
            finish_flag <= 1'b0;
            fail_flag   <= 1'b0;
            err_val     <= '0;
        end else begin
            start_q <= start;
            case (state)
                IDLE: if (accept) begin
                    loc_q       <= loc;
                    omega_q     <= omega;
                    lambda_q    <= lambda;
                    finish_flag <= 1'b0;
                    fail_flag   <= 1'b0;
                    if (loc == '0) begin
                        fail_flag <= 1'b1;
                        err_val   <= '0;
                    end
                end
                INV_LOC, INV_DEN: wcnt <= '0;
                // The inverse's finish flag is sticky, so it is only trusted after two cycles.
                WAIT_LOC: begin
                    if (wcnt != 2'd2) wcnt <= wcnt + 2'd1;
                    else if (inv_done) begin
                        xinv <= inv_z;
                        num  <= '0;
                        den  <= '0;
                        idx  <= IW'(T-1);
                    end
                end
                EVAL: begin
                    num <= gf_mul(num, xinv) ^ om_coef;
                    den <= gf_mul(den, xinv) ^ dl_coef;
                    idx <= idx - IW'(1);
                end
                CHECK: if (den == '0) begin
                    fail_flag <= 1'b1;
                    err_val   <= '0;
                end
                WAIT_DEN: begin
                    if (wcnt != 2'd2) wcnt <= wcnt + 2'd1;
                    else if (inv_done) deninv <= inv_z;
`ifdef GF26_FORNEY_FCR0_EN
                    mul_phase <= 1'b0;
`endif
                end
`ifdef GF26_FORNEY_FCR0_EN
                MUL: begin
                    if (!mul_phase) begin
                        err_val   <= gf_mul(num, deninv);
                        mul_phase <= 1'b1;
                    end else begin
                        err_val <= gf_mul(err_val, loc_q);
                    end
                end
`else
                MUL: err_val <= gf_mul(num, deninv);
`endif
                default: ;
            endcase
            if (next_state == DONE && state != DONE) finish_flag <= 1'b1;
        end
    end
endmodule

// File: tb/tb_gf26_forney.sv
// Scoreboard bench for gf26_forney: expected {fail, err_val} queued at start, compared at finish_flag.
module tb_gf26_forney;
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  loc = '0;
    logic [17:0] omega = '0;
    logic [23:0] lambda = '0;
    logic        busy, finish_flag, fail_flag;
    logic [5:0]  err_val;

    logic [6:0]  exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    gf26_forney dut (
        .clk         (clk),
        .resetN      (resetN),
        .start       (start),
        .loc         (loc),
        .omega       (omega),
        .lambda      (lambda),
        .busy        (busy),
        .finish_flag (finish_flag),
        .fail_flag   (fail_flag),
        .err_val     (err_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic: carry-less product then polynomial division by x^6+x+1.
    function automatic logic [5:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
        logic [10:0] p;
        p = '0;
        for (int i = 0; i < 6; i++) if (b[i]) p = p ^ (11'(a) << i);
        for (int k = 10; k >= 6; k--) if (p[k]) p = p ^ (11'h43 << (k - 6));
        return p[5:0];
    endfunction

    function automatic logic [5:0] ref_inv(input logic [5:0] a);
        for (int y = 1; y < 64; y++) if (ref_mul(a, 6'(y)) == 6'h01) return 6'(y);
        return 6'h00;
    endfunction

    function automatic logic [6:0] ref_forney(input logic [5:0] l, input logic [17:0] om, input logic [23:0] la);
        logic [5:0] xi, pw, nm, dn, e;
        if (l == 6'h00) return {1'b1, 6'h00};
        xi = ref_inv(l);
        nm = '0;
        pw = 6'h01;
        for (int j = 0; j < 3; j++) begin
            nm = nm ^ ref_mul(om[6*j +: 6], pw);
            pw = ref_mul(pw, xi);
        end
        dn = '0;
        pw = 6'h01;
        for (int i = 1; i <= 3; i++) begin
            if (i % 2 == 1) dn = dn ^ ref_mul(la[6*i +: 6], pw);
            pw = ref_mul(pw, xi);
        end
        if (dn == 6'h00) return {1'b1, 6'h00};
        e = ref_mul(nm, ref_inv(dn));
`ifdef GF26_FORNEY_FCR0_EN
        e = ref_mul(e, l);
`endif
        return {1'b0, e};
    endfunction

    // Waits (bounded) for finish_flag; returns cycles since the start edge.
    task automatic wait_done(input string tag, output int cycles);
        int n = 1;
        while (!finish_flag && n < 400) begin
            @(negedge clk);
            n++;
        end
        cycles = n;
        if (!finish_flag) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic compare_result(input string tag);
        logic [6:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_no_expect"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check(tag, {fail_flag, err_val}, exp);
        end
    endtask

    task automatic drive(input logic [5:0] l, input logic [17:0] om, input logic [23:0] la, input logic [6:0] exp);
        @(negedge clk);
        loc = l; omega = om; lambda = la; start = 1'b1;
        exp_q.push_back(exp);
    endtask

    task automatic run_case(input string tag, input logic [5:0] l, input logic [17:0] om,
                            input logic [23:0] la, input logic [6:0] exp, output int cycles);
        drive(l, om, la, exp);
        @(negedge clk);
        start = 1'b0;
        wait_done(tag, cycles);
        if (finish_flag) compare_result(tag);
        else void'(exp_q.pop_front());
    endtask

    localparam logic [17:0] OM_C1 = {6'h00, 6'h00, 6'h05};
    localparam logic [23:0] LA_C1 = {6'h00, 6'h00, 6'h01, 6'h01};
    localparam logic [17:0] OM_C2 = {6'h00, 6'h00, 6'h0E};
    localparam logic [23:0] LA_C2 = {6'h00, 6'h00, 6'h02, 6'h01};
`ifdef GF26_FORNEY_FCR0_EN
    localparam logic [6:0]  EXP_C2 = {1'b0, 6'h0E};
`else
    localparam logic [6:0]  EXP_C2 = {1'b0, 6'h07};
`endif

    initial begin
        int cyc;
        int busy_cnt;
        logic [5:0]  rl;
        logic [17:0] rom;
        logic [23:0] rla;

        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, finish_flag, fail_flag, err_val}, 32'h0);
        resetN = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {busy, finish_flag}, 32'h0);

        run_case("case1_loc1", 6'h01, OM_C1, LA_C1, {1'b0, 6'h05}, cyc);
        check("case1_finish", finish_flag, 1'b1);
        run_case("case2_loc2", 6'h02, OM_C2, LA_C2, EXP_C2, cyc);
        run_case("den_zero", 6'h02, OM_C2, {6'h00, 6'h00, 6'h00, 6'h01}, {1'b1, 6'h00}, cyc);
        run_case("loc_zero", 6'h00, OM_C1, LA_C1, {1'b1, 6'h00}, cyc);
        check("loc_zero_latency_ok", 32'(cyc <= 3), 32'd1);
        run_case("num_zero", 6'h05, 18'h0, LA_C2, {1'b0, 6'h00}, cyc);
`ifdef GF26_FORNEY_FCR0_EN
        run_case("fcr0_case", 6'h02, {6'h00, 6'h00, 6'h07}, LA_C2, {1'b0, 6'h07}, cyc);
`else
        run_case("fcr1_case", 6'h02, {6'h00, 6'h00, 6'h07}, LA_C2, ref_forney(6'h02, {6'h00, 6'h00, 6'h07}, LA_C2), cyc);
`endif

        // Start held high across completion: one run, flag sticks.
        drive(6'h01, OM_C1, LA_C1, {1'b0, 6'h05});
        @(negedge clk);
        wait_done("held_high", cyc);
        if (finish_flag) compare_result("held_high");
        else void'(exp_q.pop_front());
        busy_cnt = 0;
        repeat (20) begin @(negedge clk); if (busy) busy_cnt++; end
        check("held_high_no_rerun", busy_cnt, 0);
        start = 1'b0;
        @(negedge clk);
        check("held_high_flag_kept", finish_flag, 1'b1);

        // Fresh edge clears the flag; a second pulse while busy is ignored.
        drive(6'h02, OM_C2, LA_C2, EXP_C2);
        @(negedge clk);
        check("edge_clears_finish", finish_flag, 1'b0);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_mid_run", busy, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_pulse", cyc);
        if (finish_flag) compare_result("busy_pulse");
        else void'(exp_q.pop_front());
        busy_cnt = 0;
        repeat (30) begin @(negedge clk); if (busy) busy_cnt++; end
        check("busy_pulse_single_run", busy_cnt, 0);
        check("busy_pulse_flag_kept", finish_flag, 1'b1);

        // Asynchronous reset deep inside the second inverse wait.
        @(negedge clk);
        loc = 6'h02; omega = OM_C2; lambda = LA_C2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("busy_before_reset", busy, 1'b1);
        #2 resetN = 1'b0;
        #1 check("async_reset_outputs", {busy, finish_flag, fail_flag, err_val}, 32'h0);
        @(negedge clk);
        resetN = 1'b1;
        run_case("case2_after_reset", 6'h02, OM_C2, LA_C2, EXP_C2, cyc);

        for (int r = 0; r < 6; r++) begin
            rl  = 6'($urandom_range(1, 63));
            rom = 18'($urandom);
            rla = 24'($urandom);
            run_case($sformatf("rand%0d", r), rl, rom, rla, ref_forney(rl, rom, rla), cyc);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gf26_forney.md
Name: gf26_forney

Overview:
- Forney error-magnitude stage of the GF(2^6) Reed-Solomon decoder.
- For one error location X it computes e = Omega(X^-1) / Lambda'(X^-1).
- Consumes Omega and Lambda from the key-equation solver and error locations from the Chien search; its output goes to the codeword correction stage.
- Instantiates one gf26_inverse and reuses it twice: first for X^-1, then for 1/Lambda'.

Parameters:
- T, 3, error-correcting capability. Omega has T coefficients; Lambda has T+1 coefficients.
- M, 6, field width. Fixed; field polynomial x^6+x+1, alpha = 6'h02.

Ports:
- clk  in  1  system clock
- resetN  in  1  reset
- start  in  1  a rising edge begins one computation
- loc  in  M  error locator X = alpha^i; sampled on the start edge
- omega  in  M*T  Omega coefficients; coeff j at bits [M*j+M-1 : M*j]; sampled on the start edge
- lambda  in  M*(T+1)  Lambda coefficients, same packing; sampled on the start edge
- busy  out  1  high from the cycle after the accepted edge until DONE
- finish_flag  out  1  result valid; held until the next accepted start
- fail_flag  out  1  uncorrectable result; valid when finish_flag=1
- err_val  out  M  error magnitude

Behaviour:
- Reset: one clock, asynchronous active-low reset resetN (clk / resetN). busy=0, finish_flag=0, fail_flag=0, err_val=0, state IDLE, internal registers 0. Reset mid-operation aborts immediately and leaves no residue.
- Start detection: start is registered. An edge is accepted only in IDLE (start=1 and registered start=0). Edges seen while busy are ignored.
- Accepted edge: latch loc, omega and lambda, clear finish_flag and fail_flag in the same cycle.
- States: IDLE, INV_LOC, WAIT_LOC, EVAL, CHECK, INV_DEN, WAIT_DEN, MUL, DONE.
- IDLE -> INV_LOC on an accepted edge. If loc==0, go directly to DONE with fail_flag=1 and err_val=0.
- INV_LOC: drive the inverse start high for exactly one cycle with base = latched loc.
- WAIT_LOC: ignore the inverse finish_flag for 2 cycles, because it is sticky from the previous run. Then wait for it to be 1, capture z as xinv, and go to EVAL.
- EVAL: Horner evaluation, one coefficient per cycle, T cycles, highest coefficient first.
  - num = num*xinv ^ omega[j], for j = T-1 down to 0.
  - den accumulates Lambda' over odd-index coefficients only (characteristic 2): Lambda'(x) = sum over odd i of lambda_i * x^(i-1), evaluated over the same T cycles.
  - Accumulators are cleared on entry.
- CHECK: if den==0, go to DONE with fail_flag=1 and err_val=0. Otherwise go to INV_DEN.
- INV_DEN / WAIT_DEN: same handshake as INV_LOC / WAIT_LOC with base = den; capture deninv.
- MUL: err_val <= num*deninv (combinational GF multiply, reduction by x^6+x+1), then go to DONE.
- DONE: finish_flag=1 and busy=0. Go to IDLE next cycle; outputs hold until the next accepted edge.
- Zero numerator with nonzero den is legal: err_val=0 and fail_flag=0.
- Latency: data-dependent through gf26_inverse. The bench uses the handshake with a 400-cycle timeout and never relies on a fixed count.
- All GF arithmetic is M bits wide. Addition is XOR; no carries.

Optional Feature:
- Macro GF26_FORNEY_FCR0_EN selects the first consecutive root.
- Defined: first consecutive root alpha^0. MUL adds one extra cycle computing err_val = loc*num*deninv.
- Undefined: first consecutive root alpha^1. err_val = num*deninv with no extra cycle.
- fail rules are identical in both builds.

Test Plan:
- Build without the macro, loc=6'h01, omega={0,0,6'h05}, lambda={0,0,6'h01,6'h01}, start edge -> finish_flag=1, fail_flag=0, err_val=6'h05.
- loc=6'h02, omega0=6'h0E (7*alpha), lambda={0,0,6'h02,6'h01} -> err_val=6'h07, fail_flag=0.
- lambda1=lambda3=0, loc=6'h02, omega0=6'h0E -> fail_flag=1, err_val=6'h00; loc=0 -> fail_flag=1 within 3 cycles of the edge.
- Start held high across completion, then a second start pulse while busy -> exactly one computation; finish_flag stays high until the next low-to-high edge in IDLE.
- resetN asserted during WAIT_DEN -> all outputs 0 asynchronously; a fresh start afterwards gives the correct err_val for case 2.
- GF26_FORNEY_FCR0_EN defined, loc=6'h02, omega0=6'h07, lambda={0,0,6'h02,6'h01} -> err_val=6'h07 (num=7, den=2, times loc=2).
